// File: rtl/ped_request_pkg.sv
// Shared state encodings and parameter defaults for the pedestrian request block.
// No logic, so no latency or backpressure.
package ped_request_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_SERVING = 2'b10
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;

endpackage

// File: rtl/ped_debounce.sv
// Button conditioner: two-flop synchronizer, debounce counter and press-edge detect.
// Press pulses DEBOUNCE_CYCLES+2 edges after a raw level change. No backpressure.
module ped_debounce
    import ped_request_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the debounced one.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            prev_q  <= db_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = db_q & ~prev_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian request FSM: debounced presses raise Ped until the stoplight shows red.
// Ped rises one edge after a press in IDLE; no backpressure, extra presses are queued once or absorbed.
module ped_request
    import ped_request_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    input  logic SigR,
    output logic Ped,
    output logic Served,
    output logic Queued
);

    state_e state_q, state_d;
    logic   queued_q, queued_d;
    logic   ped_q, ped_d;
    logic   served_q, served_d;
    logic   press;

    ped_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db (
        .clk_i     (clock),
        .rst_i     (reset),
        .btn_raw_i (button_raw),
        .press_o   (press)
    );

    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = SigR ? ST_SERVING : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (SigR) begin
                    state_d = ST_SERVING;
                end
            end
            ST_SERVING: begin
                // A press landing on the same edge as red dropping still counts as queued.
                if (!SigR) begin
                    state_d  = (queued_q || press) ? ST_ARMED : ST_IDLE;
                    queued_d = 1'b0;
                end else if (press) begin
                    queued_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                queued_d = 1'b0;
            end
        endcase
        ped_d    = (state_d == ST_ARMED);
        served_d = (state_d == ST_SERVING) && (state_q != ST_SERVING);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            queued_q <= 1'b0;
            ped_q    <= 1'b0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            queued_q <= queued_d;
            ped_q    <= ped_d;
            served_q <= served_d;
        end
    end

    assign Ped    = ped_q;
    assign Served = served_q;
    assign Queued = queued_q;

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request: latency, bounce rejection, service, queueing and reset.
module tb_ped_request;
    import ped_request_pkg::*;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset;
    logic button_raw;
    logic SigR;
    logic Ped;
    logic Served;
    logic Queued;

    int vectors     = 0;
    int miscompares = 0;

    logic [19:0] bounce_pat;

    always #5 clock = ~clock;

    ped_request #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button_raw (button_raw),
        .SigR       (SigR),
        .Ped        (Ped),
        .Served     (Served),
        .Queued     (Queued)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        button_raw = 1'b0;
        SigR       = 1'b0;
        #2;
        chk("rst_ped",    Ped,         2'd0);
        chk("rst_served", Served,      2'd0);
        chk("rst_queued", Queued,      2'd0);
        chk("rst_state",  dut.state_q, ST_IDLE);
        tick(2);
        reset = 1'b0;
        tick(3);

        // Clean press, SigR low: Ped after D+2 edges from first sample.
        button_raw = 1'b1;
        for (int i = 1; i <= D + 2; i++) begin
            tick();
            chk("clean_ped_early", Ped, 2'd0);
        end
        chk("clean_press_pulse", dut.u_db.press_o, 2'd1);
        tick();
        chk("clean_ped_high", Ped, 2'd1);
        chk("clean_state_armed", dut.state_q, ST_ARMED);
        chk("clean_press_single", dut.u_db.press_o, 2'd0);
        tick(4);
        chk("clean_ped_hold", Ped, 2'd1);
        button_raw = 1'b0;
        tick(8);
        chk("release_no_event_ped", Ped, 2'd1);
        chk("release_no_served", Served, 2'd0);

        // Service from ARMED.
        SigR = 1'b1;
        tick();
        chk("svc_ped_low", Ped, 2'd0);
        chk("svc_served_pulse", Served, 2'd1);
        chk("svc_state", dut.state_q, ST_SERVING);
        tick();
        chk("svc_served_drop", Served, 2'd0);
        tick(8);
        SigR = 1'b0;
        tick();
        chk("svc_back_idle", dut.state_q, ST_IDLE);
        chk("svc_idle_ped", Ped, 2'd0);

        // Bounce: high runs of 1..3 cycles never reach the debounce threshold.
        bounce_pat = 20'b1011_1011_0010_1110_1101;
        for (int i = 0; i < 20; i++) begin
            button_raw = bounce_pat[i];
            tick();
            chk("bounce_ped", Ped, 2'd0);
            chk("bounce_state", dut.state_q, ST_IDLE);
            chk("bounce_press", dut.u_db.press_o, 2'd0);
        end
        button_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bounce_tail_ped", Ped, 2'd0);
            chk("bounce_tail_state", dut.state_q, ST_IDLE);
        end

        // Red already on: IDLE goes straight to SERVING, Ped never rises.
        SigR       = 1'b1;
        button_raw = 1'b1;
        for (int i = 1; i <= D + 2; i++) begin
            tick();
            chk("red_ped_never", Ped, 2'd0);
        end
        tick();
        chk("red_state_serving", dut.state_q, ST_SERVING);
        chk("red_served_pulse", Served, 2'd1);
        chk("red_ped_low", Ped, 2'd0);
        chk("red_not_queued", Queued, 2'd0);
        tick();
        chk("red_served_drop", Served, 2'd0);

        // Queue a press during service; a second press keeps it set once.
        button_raw = 1'b0;
        tick(8);
        chk("q_release_none", Queued, 2'd0);
        button_raw = 1'b1;
        tick(D + 2);
        chk("q_before_press", Queued, 2'd0);
        tick();
        chk("q_set", Queued, 2'd1);
        chk("q_no_reentry", Served, 2'd0);
        button_raw = 1'b0;
        tick(8);
        button_raw = 1'b1;
        tick(D + 3);
        chk("q_second_press", Queued, 2'd1);
        chk("q_still_serving", dut.state_q, ST_SERVING);
        SigR = 1'b0;
        tick();
        chk("q_reissue_state", dut.state_q, ST_ARMED);
        chk("q_reissue_ped", Ped, 2'd1);
        chk("q_cleared", Queued, 2'd0);
        button_raw = 1'b0;
        tick(8);
        chk("q_armed_hold", Ped, 2'd1);

        // Press on the same edge SigR falls counts as queued.
        SigR = 1'b1;
        tick();
        chk("fall_served", Served, 2'd1);
        button_raw = 1'b1;
        tick(D + 2);
        chk("fall_press_ready", dut.u_db.press_o, 2'd1);
        chk("fall_not_queued_yet", Queued, 2'd0);
        SigR = 1'b0;
        tick();
        chk("fall_state_armed", dut.state_q, ST_ARMED);
        chk("fall_ped", Ped, 2'd1);
        chk("fall_queued_clear", Queued, 2'd0);

        // Press and SigR rising together in ARMED: SERVING, Queued untouched.
        button_raw = 1'b0;
        tick(8);
        button_raw = 1'b1;
        tick(D + 2);
        chk("rise_press_ready", dut.u_db.press_o, 2'd1);
        SigR = 1'b1;
        tick();
        chk("rise_state", dut.state_q, ST_SERVING);
        chk("rise_served", Served, 2'd1);
        chk("rise_queued", Queued, 2'd0);
        SigR = 1'b0;
        tick();
        chk("rise_to_idle", dut.state_q, ST_IDLE);
        button_raw = 1'b0;
        tick(8);

        // Reset mid-cycle while SERVING with a queued request.
        SigR       = 1'b1;
        button_raw = 1'b1;
        tick(D + 3);
        chk("rq_serving", dut.state_q, ST_SERVING);
        button_raw = 1'b0;
        tick(8);
        button_raw = 1'b1;
        tick(D + 3);
        chk("rq_queued", Queued, 2'd1);
        #3 reset = 1'b1;
        #1;
        chk("rq_async_queued", Queued, 2'd0);
        chk("rq_async_state", dut.state_q, ST_IDLE);
        tick(2);
        button_raw = 1'b0;
        SigR       = 1'b0;
        reset      = 1'b0;
        tick(8);

        // Reset mid-cycle while ARMED; button held through release re-registers.
        button_raw = 1'b1;
        tick(D + 3);
        chk("ra_armed_ped", Ped, 2'd1);
        tick(2);
        #3 reset = 1'b1;
        #1;
        chk("ra_async_ped", Ped, 2'd0);
        chk("ra_async_queued", Queued, 2'd0);
        chk("ra_async_state", dut.state_q, ST_IDLE);
        tick(2);
        reset = 1'b0;
        for (int i = 1; i <= D + 2; i++) begin
            tick();
            chk("ra_held_ped_early", Ped, 2'd0);
        end
        tick();
        chk("ra_held_ped_high", Ped, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
